// File: rtl/iob_axistream_out_arb_pkg.sv
// Shared definitions for the byte-stream output arbiter: FSM encoding and default sizes.
package iob_axistream_out_arb_pkg;

    localparam int N_IN_DEFAULT  = 4;
    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/iob_rr_pick.sv
// Combinational round-robin pick: the first requester above last_owner, wrapping around.
module iob_rr_pick #(
    parameter int N_IN  = 4,
    parameter int IDX_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [N_IN-1:0]  winner
);

    always_comb begin
        logic [IDX_W:0] pos;
        logic           found;
        winner = '0;
        found  = 1'b0;
        pos    = '0;
        // k = 1 is checked first, so the previous owner has the lowest priority
        for (int k = 1; k <= N_IN; k++) begin
            pos = {1'b0, last_owner} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(N_IN)) begin
                pos = pos - (IDX_W+1)'(N_IN);
            end
            for (int j = 0; j < N_IN; j++) begin
                if (!found && req[j] && (pos == (IDX_W+1)'(j))) begin
                    winner[j] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/iob_axistream_out_arb.sv
// Packet-locked round-robin arbiter of N_IN byte streams onto one registered output stream.
// Optional per-input completed-packet counters are built when IOB_AXISTREAM_OUT_ARB_CNT_EN is defined.
module iob_axistream_out_arb
    import iob_axistream_out_arb_pkg::*;
#(
    parameter int N_IN  = N_IN_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*N_IN-1:0]     s_tdata,
    input  logic [N_IN-1:0]       s_tvalid,
    input  logic [N_IN-1:0]       s_tlast,
    output logic [N_IN-1:0]       s_tready,
    output logic [7:0]            m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic [N_IN-1:0]       grant,
    output logic                  busy
`ifdef IOB_AXISTREAM_OUT_ARB_CNT_EN
    ,
    output logic [N_IN*CNT_W-1:0] pkt_cnt
`endif
);

    localparam int IDX_W = $clog2(N_IN);

    if (N_IN < 2 || N_IN > 8 || CNT_W < 1) begin : g_bad_param
        $error("iob_axistream_out_arb: N_IN must be 2..8 and CNT_W at least 1");
    end

    arb_state_t       state_q;
    logic [N_IN-1:0]  grant_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] last_q;
    logic             m_tvalid_q;
    logic             m_tlast_q;
    logic [7:0]       m_tdata_q;

    logic [N_IN-1:0]  winner;
    logic [IDX_W-1:0] win_idx;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic             out_free;
    logic             beat_acc;

    iob_rr_pick #(
        .N_IN  (N_IN),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req        (s_tvalid),
        .last_owner (last_q),
        .winner     (winner)
    );

    // The output register can take a beat when empty or when it drains this cycle
    assign out_free = ~m_tvalid_q | m_tready;
    assign s_tready = (state_q == ST_XFER) ? (grant_q & {N_IN{out_free}}) : '0;
    assign beat_acc = |(s_tvalid & s_tready);

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        win_idx  = '0;
        for (int j = 0; j < N_IN; j++) begin
            if (grant_q[j]) begin
                sel_data = s_tdata[8*j +: 8];
                sel_last = s_tlast[j];
            end
            if (winner[j]) begin
                win_idx = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            last_q     <= IDX_W'(N_IN-1);
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tdata_q  <= '0;
        end else begin
            if (beat_acc) begin
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= sel_data;
                m_tlast_q  <= sel_last;
            end else if (m_tready) begin
                m_tvalid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (|s_tvalid) begin
                        grant_q <= winner;
                        owner_q <= win_idx;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (beat_acc && sel_last) begin
                        grant_q <= '0;
                        last_q  <= owner_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign grant    = grant_q;
    assign busy     = (state_q == ST_XFER) | m_tvalid_q;

`ifdef IOB_AXISTREAM_OUT_ARB_CNT_EN
    logic [CNT_W-1:0] cnt_q [N_IN];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N_IN; j++) begin
                cnt_q[j] <= '0;
            end
        end else if (beat_acc && sel_last) begin
            for (int j = 0; j < N_IN; j++) begin
                if (grant_q[j]) begin
                    cnt_q[j] <= cnt_q[j] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar j = 0; j < N_IN; j++) begin : g_cnt_out
        assign pkt_cnt[j*CNT_W +: CNT_W] = cnt_q[j];
    end
`endif

endmodule

// File: tb/tb_iob_axistream_out_arb.sv
// Directed and randomized bench for iob_axistream_out_arb against a packet-level round-robin model.
module tb_iob_axistream_out_arb;

    localparam int N  = 4;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [8*N-1:0] s_tdata;
    logic [N-1:0]   s_tvalid, s_tlast, s_tready, grant;
    logic [7:0]     m_tdata;
    logic           m_tvalid, m_tlast, m_tready, busy;
`ifdef IOB_AXISTREAM_OUT_ARB_CNT_EN
    logic [N*CW-1:0] pkt_cnt;
`endif

    always #5 clk = ~clk;

    iob_axistream_out_arb #(.N_IN(N), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .grant    (grant),
        .busy     (busy)
`ifdef IOB_AXISTREAM_OUT_ARB_CNT_EN
        ,
        .pkt_cnt  (pkt_cnt)
`endif
    );

    logic [8:0] src_q [N][$];
    logic [8:0] out_q[$];
    logic [8:0] exp_q[$];
    int         out_cyc[$];
    int         acc_cyc[$];
    int         grant_log[$];
    int         exp_grant[$];
    int         hold [N];
    int         rdy_mode;
    int         gap_en;
    int         cyc, nerr, nchk, m_last;
    logic [N-1:0] grant_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic [8:0] b;
        for (int i = 0; i < N; i++) begin
            if (gap_en != 0 && grant[i] && hold[i] == 0 && $urandom_range(0, 3) == 0) hold[i] = 1;
            if (src_q[i].size() > 0 && hold[i] == 0) begin
                b = src_q[i][0];
                s_tvalid[i]      = 1'b1;
                s_tdata[8*i +: 8] = b[7:0];
                s_tlast[i]       = b[8];
            end else begin
                s_tvalid[i]      = 1'b0;
                s_tdata[8*i +: 8] = 8'($urandom);
                s_tlast[i]       = 1'($urandom);
            end
            if (hold[i] > 0) hold[i]--;
        end
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ($urandom_range(0, 2) != 0);
            default: m_tready = 1'b0;
        endcase
    endtask

    // One clock: drive after the edge, observe at the falling edge what the next edge will do
    task automatic tick();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        cyc++;
        if (!rst) begin
            chk("s_tready_rule", s_tready, grant & {N{~m_tvalid | m_tready}});
            chk("busy_rule", busy, (grant != '0) | m_tvalid);
            chk("grant_onehot0", $onehot0(grant), 1'b1);
            for (int i = 0; i < N; i++) begin
                if (s_tvalid[i] && s_tready[i]) begin
                    void'(src_q[i].pop_front());
                    acc_cyc.push_back(cyc);
                end
            end
            if (m_tvalid && m_tready) begin
                out_q.push_back({m_tlast, m_tdata});
                out_cyc.push_back(cyc);
            end
            if (grant_prev == '0 && grant != '0) begin
                for (int i = 0; i < N; i++) if (grant[i]) grant_log.push_back(i);
            end
        end
        grant_prev = grant;
    endtask

    task automatic flush_logs();
        out_q.delete(); out_cyc.delete(); acc_cyc.delete(); grant_log.delete();
        exp_q.delete(); exp_grant.delete();
    endtask

    // Packet-level model: each packet goes out whole; next owner is the first
    // input with a pending packet after the previous owner, wrapping.
    task automatic build_expected();
        logic [8:0] t [N][$];
        logic [8:0] b;
        int pick;
        for (int i = 0; i < N; i++) t[i] = src_q[i];
        while (1) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                if (pick < 0 && t[(m_last + k) % N].size() > 0) pick = (m_last + k) % N;
            end
            if (pick < 0) break;
            do begin
                b = t[pick].pop_front();
                exp_q.push_back(b);
            end while (!b[8] && t[pick].size() > 0);
            exp_grant.push_back(pick);
            m_last = pick;
        end
    endtask

    task automatic push_pkt(input int i, input int len, input logic [7:0] base);
        for (int j = 0; j < len; j++) src_q[i].push_back({(j == len - 1), 8'(base + 8'(j))});
    endtask

    task automatic run_and_compare(input string tag, input int budget);
        int n;
        bit empty;
        n = 0;
        while (n < budget) begin
            empty = 1;
            for (int i = 0; i < N; i++) if (src_q[i].size() > 0) empty = 0;
            if (empty && out_q.size() >= exp_q.size() && !busy) break;
            tick();
            n++;
        end
        chk({tag, "_drain_in_time"}, (n < budget), 1'b1);
        chk({tag, "_byte_count"}, out_q.size(), exp_q.size());
        for (int k = 0; k < out_q.size() && k < exp_q.size(); k++) chk({tag, "_byte"}, out_q[k], exp_q[k]);
        chk({tag, "_grant_count"}, grant_log.size(), exp_grant.size());
        for (int k = 0; k < grant_log.size() && k < exp_grant.size(); k++) chk({tag, "_grant_order"}, grant_log[k], exp_grant[k]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin src_q[i].delete(); hold[i] = 0; end
        tick();
        rst = 1'b0;
        m_last = N - 1;
    endtask

    logic [7:0] held;
    int         n;

    initial begin
        nerr = 0; nchk = 0; cyc = 0; rdy_mode = 0; gap_en = 0; grant_prev = '0;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1; rst = 1'b1;
        for (int i = 0; i < N; i++) hold[i] = 0;

        // Reset state
        do_reset();
        rst = 1'b1;
        tick();
        chk("rst_grant", grant, 4'b0000);
        chk("rst_s_tready", s_tready, 4'b0000);
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        chk("rst_m_tlast", m_tlast, 1'b0);
        chk("rst_m_tdata", m_tdata, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_no_req_grant", grant, 4'b0000);

        // Four 3-byte packets, all inputs requesting
        flush_logs();
        for (int i = 0; i < N; i++) push_pkt(i, 3, 8'(8'h10 * (i + 1)));
        build_expected();
        run_and_compare("rr4x3", 200);
        chk("rr4x3_nbytes", out_q.size(), 12);
        for (int k = 0; k < 12 && k < out_q.size(); k++) begin
            chk("rr4x3_tlast_pos", out_q[k][8], ((k % 3) == 2));
        end
        for (int k = 0; k < 4 && k < grant_log.size(); k++) chk("rr4x3_grant_seq", grant_log[k], k);

        // Single packet on input 2: latency and back-to-back throughput
        flush_logs();
        src_q[2].push_back({1'b0, 8'hA1});
        src_q[2].push_back({1'b0, 8'hA2});
        src_q[2].push_back({1'b1, 8'hA3});
        build_expected();
        run_and_compare("in2_pkt", 100);
        if (out_cyc.size() == 3 && acc_cyc.size() == 3) begin
            chk("in2_latency", out_cyc[0], acc_cyc[0] + 1);
            chk("in2_b2b_1", out_cyc[1], out_cyc[0] + 1);
            chk("in2_b2b_2", out_cyc[2], out_cyc[0] + 2);
        end else begin
            chk("in2_beat_logs", out_cyc.size() * 16 + acc_cyc.size(), 3 * 16 + 3);
        end

        // Backpressure for 5 cycles during a packet on input 1
        flush_logs();
        push_pkt(1, 8, 8'h30);
        build_expected();
        for (n = 0; n < 50 && out_q.size() < 2; n++) tick();
        chk("stall_reach", out_q.size() >= 2, 1'b1);
        rdy_mode = 2;
        tick();
        held = m_tdata;
        chk("stall_valid", m_tvalid, 1'b1);
        chk("stall_s_tready1", s_tready[1], 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stall_valid", m_tvalid, 1'b1);
            chk("stall_data_held", m_tdata, held);
            chk("stall_s_tready1", s_tready[1], 1'b0);
        end
        rdy_mode = 0;
        run_and_compare("stall", 100);

        // Reset in the middle of a 4-byte packet
        flush_logs();
        push_pkt(1, 4, 8'h50);
        for (n = 0; n < 50 && acc_cyc.size() < 2; n++) tick();
        chk("midrst_reach", acc_cyc.size(), 2);
        do_reset();
        chk("midrst_m_tvalid", m_tvalid, 1'b0);
        chk("midrst_grant", grant, 4'b0000);
        tick();
        chk("postrst_m_tvalid", m_tvalid, 1'b0);
        flush_logs();
        push_pkt(1, 2, 8'h60);
        push_pkt(0, 2, 8'h70);
        build_expected();
        for (n = 0; n < 10 && grant == '0; n++) tick();
        chk("postrst_first_grant", grant, 4'b0001);
        run_and_compare("postrst", 100);

        // Input 0 drops valid mid-packet while input 3 waits
        do_reset();
        flush_logs();
        push_pkt(0, 4, 8'h80);
        push_pkt(3, 2, 8'h90);
        build_expected();
        for (n = 0; n < 50 && acc_cyc.size() < 2; n++) tick();
        chk("gap_reach", acc_cyc.size(), 2);
        hold[0] = 3;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("gap_grant_locked", grant, 4'b0001);
        end
        for (n = 0; n < 50 && src_q[0].size() > 0; n++) begin
            chk("gap_grant_until_tlast", grant, 4'b0001);
            tick();
        end
        run_and_compare("gap", 100);

        // Randomized rounds: random packets, random backpressure, random valid gaps
        for (int r = 0; r < 8; r++) begin
            flush_logs();
            rdy_mode = 1;
            gap_en = 1;
            for (int i = 0; i < N; i++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) push_pkt(i, $urandom_range(1, 5), 8'($urandom));
            end
            build_expected();
            run_and_compare("rand", 3000);
        end
        rdy_mode = 0;
        gap_en = 0;

`ifdef IOB_AXISTREAM_OUT_ARB_CNT_EN
        // 17 packets on input 1 with a 4-bit counter wrap to 1
        do_reset();
        flush_logs();
        for (int p = 0; p < 17; p++) push_pkt(1, 1, 8'(p));
        build_expected();
        run_and_compare("cnt17", 500);
        for (int i = 0; i < N; i++) begin
            chk("pkt_cnt", pkt_cnt[i*CW +: CW], (i == 1) ? ((17 % (1 << CW))) : 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
